slow_clock_monitor: RTL and testbench

- Receive-side companion to the team's clock dividers: takes a divided slow clock as a plain data input and samples it in the fast clkin domain.
- Synchronizes the input and emits single-cycle rising and falling edge strobes, which downstream logic uses as clock enables.
- Measures every half-period in clkin cycles and declares lock after repeated in-tolerance measurements.
- Flags loss when the input stops toggling.

---
 rtl/slow_clock_monitor_pkg.sv | 29 ++
 rtl/slow_clock_monitor_if.sv | 49 ++++
 rtl/sync_2ff.sv | 34 +++
 rtl/slow_clock_monitor.sv | 185 ++++++++++++++++++
 tb/tb_slow_clock_monitor.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/slow_clock_monitor_pkg.sv
// -----------------------------------------------------------------------------
// slow_clock_monitor_pkg
//   Shared definitions for the slow-clock monitor and the clock dividers that
//   feed it. The default half-period and timeout live here so both ends of the
//   link agree on the same terminal count.
//   Contents:
//     mon_state_e          monitor FSM state encoding (ACQUIRE/TRACK/LOCKED/LOST)
//     DEF_EXPECTED_HALF    nominal half-period of the divided clock, clkin cycles
//     DEF_TOL              allowed absolute deviation of one measurement
//     DEF_LOCK_COUNT       consecutive good measurements needed for lock
//     DEF_TIMEOUT          cycles without an edge before loss is declared
//     DEF_CNT_W            counter width, wide enough for DEF_TIMEOUT
// -----------------------------------------------------------------------------
package slow_clock_monitor_pkg;

   typedef enum logic [1:0] {
      ST_ACQUIRE = 2'd0,
      ST_TRACK   = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_LOST    = 2'd3
   } mon_state_e;

   localparam int unsigned DEF_EXPECTED_HALF = 50001;
   localparam int unsigned DEF_TOL           = 2;
   localparam int unsigned DEF_LOCK_COUNT    = 4;
   localparam int unsigned DEF_TIMEOUT       = 100002;
   localparam int unsigned DEF_CNT_W         = 17;

endpackage

// File: rtl/slow_clock_monitor_if.sv
// -----------------------------------------------------------------------------
// slow_clock_monitor_if
//   Bundles the observed divided clock and the monitor's result signals.
//   Signals:
//     slow_in       divided clock under observation (asynchronous, plain data)
//     rise_pulse    one-cycle strobe per detected rising edge
//     fall_pulse    one-cycle strobe per detected falling edge
//     half_period   most recent valid half-period measurement (CNT_W bits)
//     period_valid  one-cycle strobe, half_period updated this cycle
//     locked        level, monitor is in LOCKED
//     lost          level, monitor is in LOST
//     state_dbg     current FSM state, for checkers and debug
//   Modports:
//     master  the side producing slow_in and consuming the results
//     slave   the monitor itself
//
//   Signalling: there is no valid/ready handshake. rise_pulse, fall_pulse and
//   period_valid are single-cycle strobes with no back-pressure; a consumer
//   must take them in the cycle they are high. half_period is only meaningful
//   from the cycle period_valid is high and holds until the next strobe.
//   locked/lost are levels and change in the same cycle as period_valid.
// -----------------------------------------------------------------------------
interface slow_clock_monitor_if #(
   parameter int unsigned CNT_W = slow_clock_monitor_pkg::DEF_CNT_W
) ();
   import slow_clock_monitor_pkg::*;

   logic             slow_in;
   logic             rise_pulse;
   logic             fall_pulse;
   logic [CNT_W-1:0] half_period;
   logic             period_valid;
   logic             locked;
   logic             lost;
   mon_state_e       state_dbg;

   modport master (
      output slow_in,
      input  rise_pulse, fall_pulse, half_period, period_valid,
      input  locked, lost, state_dbg
   );

   modport slave (
      input  slow_in,
      output rise_pulse, fall_pulse, half_period, period_valid,
      output locked, lost, state_dbg
   );

endinterface

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   One-bit two-flop synchronizer for sampling an asynchronous level (such as
//   a divided clock) into the clk_i domain. Reusable by any block that watches
//   a divided clock.
//   Ports:
//     clk_i  destination clock
//     rst_i  synchronous active-high reset, clears both flops
//     d_i    asynchronous input
//     q_o    synchronized output, two clk_i cycles behind d_i
// -----------------------------------------------------------------------------
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/slow_clock_monitor.sv
// -----------------------------------------------------------------------------
// slow_clock_monitor
//   Receive-side companion to the clock dividers. Samples a divided clock as
//   data in the clkin domain, emits edge strobes usable as clock enables,
//   measures every half-period, declares lock after LOCK_COUNT consecutive
//   in-tolerance measurements and flags loss when the input stops toggling.
//   Ports:
//     clkin   fast system clock, all logic on its rising edge
//     reset   synchronous active-high reset
//     mon_if  slave modport: slow_in in; rise_pulse, fall_pulse, half_period,
//             period_valid, locked, lost, state_dbg out
//   The interface instance must be built with the same CNT_W as this module.
// -----------------------------------------------------------------------------
module slow_clock_monitor
   import slow_clock_monitor_pkg::*;
#(
   parameter int unsigned EXPECTED_HALF = DEF_EXPECTED_HALF,
   parameter int unsigned TOL           = DEF_TOL,
   parameter int unsigned LOCK_COUNT    = DEF_LOCK_COUNT,
   parameter int unsigned TIMEOUT       = DEF_TIMEOUT,
   parameter int unsigned CNT_W         = DEF_CNT_W
) (
   input  logic                 clkin,
   input  logic                 reset,
   slow_clock_monitor_if.slave  mon_if
);

   localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);

   localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]  WIN_LO    = CNT_W'(EXPECTED_HALF - TOL);
   localparam logic [CNT_W-1:0]  WIN_HI    = CNT_W'(EXPECTED_HALF + TOL);
   localparam logic [GOOD_W-1:0] LOCK_C    = GOOD_W'(LOCK_COUNT);

   // ---------------------------------------------------------------------------
   // Synchronizer, history flop and edge detect
   // ---------------------------------------------------------------------------
   logic s2;
   logic s3_q;
   logic edge_det;

   sync_2ff u_sync (
      .clk_i (clkin),
      .rst_i (reset),
      .d_i   (mon_if.slow_in),
      .q_o   (s2)
   );

   always_ff @(posedge clkin) begin
      if (reset) s3_q <= 1'b0;
      else       s3_q <= s2;
   end

   assign edge_det = s2 ^ s3_q;

   // ---------------------------------------------------------------------------
   // Interval counter: restarts at 1 on an edge so an edge N cycles after the
   // previous one sees cnt_q == N; otherwise counts up and sticks at TIMEOUT.
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout;
   logic             good;

   always_comb begin
      cnt_d = cnt_q;
      if (edge_det)                cnt_d = CNT_W'(1);
      else if (cnt_q != TIMEOUT_C) cnt_d = cnt_q + CNT_W'(1);
   end

   // An edge in the same cycle the counter sits at TIMEOUT wins over loss.
   assign timeout = ~edge_det && (cnt_q == TIMEOUT_C);
   assign good    = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);

   // ---------------------------------------------------------------------------
   // Lock FSM
   // ---------------------------------------------------------------------------
   mon_state_e        state_q, state_d;
   logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
   logic              measure;

   always_comb begin
      state_d    = state_q;
      good_cnt_d = good_cnt_q;
      measure    = 1'b0;

      case (state_q)
         ST_ACQUIRE: begin
            // The first edge only starts the interval; nothing to measure yet.
            if (edge_det) begin
               state_d    = ST_TRACK;
               good_cnt_d = '0;
            end else if (timeout) begin
               state_d = ST_LOST;
            end
         end

         ST_TRACK: begin
            if (edge_det) begin
               measure = 1'b1;
               if (good) begin
                  if (good_cnt_q + GOOD_W'(1) >= LOCK_C) begin
                     good_cnt_d = LOCK_C;
                     state_d    = ST_LOCKED;
                  end else begin
                     good_cnt_d = good_cnt_q + GOOD_W'(1);
                  end
               end else begin
                  good_cnt_d = '0;
               end
            end else if (timeout) begin
               state_d = ST_LOST;
            end
         end

         ST_LOCKED: begin
            if (edge_det) begin
               measure = 1'b1;
               if (!good) begin
                  state_d    = ST_TRACK;
                  good_cnt_d = '0;
               end
            end else if (timeout) begin
               state_d = ST_LOST;
            end
         end

         ST_LOST: begin
            // The interval ending on this edge spans the outage; discard it.
            if (edge_det) begin
               state_d    = ST_TRACK;
               good_cnt_d = '0;
            end
         end

         default: begin
            state_d    = ST_ACQUIRE;
            good_cnt_d = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and output registers. locked/lost come from the next state so they
   // move in the same cycle as period_valid.
   // ---------------------------------------------------------------------------
   logic             rise_q;
   logic             fall_q;
   logic [CNT_W-1:0] half_q;
   logic             valid_q;
   logic             locked_q;
   logic             lost_q;

   always_ff @(posedge clkin) begin
      if (reset) begin
         state_q    <= ST_ACQUIRE;
         good_cnt_q <= '0;
         cnt_q      <= '0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         half_q     <= '0;
         valid_q    <= 1'b0;
         locked_q   <= 1'b0;
         lost_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         good_cnt_q <= good_cnt_d;
         cnt_q      <= cnt_d;
         rise_q     <= s2 & ~s3_q;
         fall_q     <= ~s2 & s3_q;
         if (measure) half_q <= cnt_q;
         valid_q    <= measure;
         locked_q   <= (state_d == ST_LOCKED);
         lost_q     <= (state_d == ST_LOST);
      end
   end

   assign mon_if.rise_pulse   = rise_q;
   assign mon_if.fall_pulse   = fall_q;
   assign mon_if.half_period  = half_q;
   assign mon_if.period_valid = valid_q;
   assign mon_if.locked       = locked_q;
   assign mon_if.lost         = lost_q;
   assign mon_if.state_dbg    = state_q;

endmodule

// File: tb/tb_slow_clock_monitor.sv
// -----------------------------------------------------------------------------
// tb_slow_clock_monitor
//   Directed scenarios followed by random half-periods. A timestamp-based
//   reference model predicts every output on every cycle.
// -----------------------------------------------------------------------------
module tb_slow_clock_monitor;
   import slow_clock_monitor_pkg::*;

   localparam int EXP_HALF = 10;
   localparam int TOL      = 1;
   localparam int LOCK_N   = 4;
   localparam int TOUT     = 20;
   localparam int CW       = 5;

   // model modes, numbered as the monitor's state encoding
   localparam int M_ACQ  = 0;
   localparam int M_TRK  = 1;
   localparam int M_LCK  = 2;
   localparam int M_LOST = 3;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clkin = 1'b0;
   logic reset = 1'b1;

   always #5 clkin = ~clkin;

   slow_clock_monitor_if #(.CNT_W(CW)) mon_if ();

   slow_clock_monitor #(
      .EXPECTED_HALF (EXP_HALF),
      .TOL           (TOL),
      .LOCK_COUNT    (LOCK_N),
      .TIMEOUT       (TOUT),
      .CNT_W         (CW)
   ) u_dut (
      .clkin  (clkin),
      .reset  (reset),
      .mon_if (mon_if)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard counters
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // ---------------------------------------------------------------------------
   // Reference model: slow_in samples at each posedge, edges seen two samples
   // later; interval = posedges since the previous edge (or since reset),
   // capped at the timeout.
   // ---------------------------------------------------------------------------
   int       t      = 0;
   int       anchor = 0;
   logic [2:0] hist = '0;  // hist[0] newest sample, hist[2] oldest
   int       m_mode   = M_ACQ;
   int       m_streak = 0;
   int       m_hp     = 0;
   logic     m_pv     = 1'b0;
   logic     m_rise   = 1'b0;
   logic     m_fall   = 1'b0;
   logic     cur      = 1'b0;

   task automatic model_update(input logic v, input logic r);
      int  n;
      logic ev;
      logic good;
      t++;
      if (r) begin
         hist     = '0;
         anchor   = t + 1;
         m_mode   = M_ACQ;
         m_streak = 0;
         m_hp     = 0;
         m_pv     = 1'b0;
         m_rise   = 1'b0;
         m_fall   = 1'b0;
         return;
      end
      ev     = hist[1] ^ hist[2];
      m_rise = hist[1] & ~hist[2];
      m_fall = ~hist[1] & hist[2];
      n      = (t - anchor > TOUT) ? TOUT : (t - anchor);
      m_pv   = 1'b0;
      if (ev) begin
         good = (n >= EXP_HALF - TOL) && (n <= EXP_HALF + TOL);
         if (m_mode == M_TRK || m_mode == M_LCK) begin
            m_pv = 1'b1;
            m_hp = n;
            if (good) begin
               m_streak = (m_streak + 1 > LOCK_N) ? LOCK_N : m_streak + 1;
               if (m_streak == LOCK_N) m_mode = M_LCK;
            end else begin
               m_streak = 0;
               m_mode   = M_TRK;
            end
         end else begin
            m_mode   = M_TRK;
            m_streak = 0;
         end
         anchor = t;
      end else if (n == TOUT) begin
         m_mode = M_LOST;
      end
      hist = {hist[1:0], v};
   endtask

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, t, obs, exp);
      end
   endtask

   task automatic compare_all();
      check("rise_pulse",   32'(mon_if.rise_pulse),   32'(m_rise));
      check("fall_pulse",   32'(mon_if.fall_pulse),   32'(m_fall));
      check("period_valid", 32'(mon_if.period_valid), 32'(m_pv));
      check("half_period",  32'(mon_if.half_period),  32'(m_hp));
      check("locked",       32'(mon_if.locked),       32'(m_mode == M_LCK));
      check("lost",         32'(mon_if.lost),         32'(m_mode == M_LOST));
      check("state",        32'(mon_if.state_dbg),    32'(m_mode));
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic step(input logic v, input logic r);
      mon_if.slow_in = v;
      reset          = r;
      @(posedge clkin);
      model_update(v, r);
      @(negedge clkin);
      compare_all();
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) step(cur, 1'b0);
   endtask

   // count toggles of slow_in, each followed by a half-period of n cycles
   task automatic toggles(input int n, input int count);
      for (int i = 0; i < count; i++) begin
         cur = ~cur;
         hold(n);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      mon_if.slow_in = 1'b0;

      // reset held while slow_in toggles; outputs must stay 0
      for (int i = 0; i < 10; i++) step(logic'((i / 3) % 2), 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      cur = 1'b0;

      // release, first rise, then steady 10-cycle halves to lock
      hold(5);
      toggles(10, 8);

      // one long half breaks lock, four nominal halves relock
      toggles(12, 1);
      toggles(10, 4);
      // halves at the tolerance edges keep lock
      toggles(11, 1);
      toggles(9, 1);
      toggles(10, 2);

      // input stops: loss, then recovery with the first interval discarded
      hold(45);
      toggles(10, 6);

      // edge landing exactly on the timeout count: no loss
      toggles(20, 1);
      toggles(10, 5);

      // reset mid-lock, then reacquire
      step(cur, 1'b1);
      hold(3);
      toggles(10, 7);

      // random half-periods around the nominal value
      for (int i = 0; i < 60; i++) begin
         cur = ~cur;
         hold(int'($urandom_range(7, 23)));
      end
      // random pulse widths short and long, with an occasional stop
      for (int i = 0; i < 20; i++) begin
         cur = ~cur;
         hold(($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(1, 14)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
